prog_run_checker: RTL

- Synthesizable run monitor and result checker for NCHAN CPU cores running test programs side by side.
- Detects program termination per core (halt opcode held), enforces a cycle timeout, then scans each core's result memory against an expected-value ROM.
- Reports per-channel pass/fail and the first mismatch.
- Replaces hierarchical-reference checks after a fixed delay, so FPGA self-test and simulation share one mechanism.

---
 rtl/prog_run_checker.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/prog_run_checker.sv
// Run monitor for NCHAN cores: waits for every core to hold the halt opcode,
// aborts on a cycle timeout, then scans result memories against expected ROMs.
module prog_run_checker #(
    parameter int         NCHAN     = 5,
    parameter int         WIDTH     = 32,
    parameter int         DEPTH     = 8,
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] HALT_OP   = 8'hff,
    parameter int         HALT_HOLD = 4,
    parameter int         TIMEOUT   = 11000
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [NCHAN*8-1:0]                          op_code,
    input  logic [NCHAN-1:0]                            mode,
    output logic [ADDR_W-1:0]                           res_addr,
    input  logic [NCHAN*WIDTH-1:0]                      res_data,
    input  logic [NCHAN*WIDTH-1:0]                      exp_data,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        timeout,
    output logic [NCHAN-1:0]                            halted,
    output logic [NCHAN-1:0]                            pass,
    output logic                                        fail_valid,
    output logic [((NCHAN > 1) ? $clog2(NCHAN) : 1)-1:0] fail_chan,
    output logic [ADDR_W-1:0]                           fail_addr,
    output logic [WIDTH-1:0]                            fail_found,
    output logic [WIDTH-1:0]                            fail_exp,
    output logic [31:0]                                 cycles
);

    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int HW = $clog2(HALT_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_n;

    logic [HW-1:0]     hold [NCHAN];
    logic [NCHAN-1:0]  is_halt_op;
    logic [NCHAN-1:0]  new_halt;
    logic [NCHAN-1:0]  halted_n;
    logic [NCHAN-1:0]  mism_v;
    logic [NCHAN-1:0]  ok;
    logic [NCHAN-1:0]  ok_n;
    logic              all_halt;
    logic              tmo_hit;
    logic              issue_done;
    logic              cmp_v;
    logic [ADDR_W-1:0] cmp_a;
    logic              cmp_last;
    logic [CW-1:0]     first_ch;
    logic [WIDTH-1:0]  first_res;
    logic [WIDTH-1:0]  first_exp;

    // Per-channel halt detection and compare results for the word in flight.
    always_comb begin
        is_halt_op = '0;
        new_halt   = '0;
        mism_v     = '0;
        first_ch   = '0;
        first_res  = '0;
        first_exp  = '0;
        for (int i = 0; i < NCHAN; i++) begin
            is_halt_op[i] = (op_code[8*i +: 8] == HALT_OP);
            new_halt[i]   = is_halt_op[i] && (hold[i] == HW'(HALT_HOLD - 1));
            if (mode[i]) begin
                mism_v[i] = cmp_v && ((res_data[WIDTH*i +: WIDTH] != '0) != exp_data[WIDTH*i]);
            end else begin
                mism_v[i] = cmp_v && (res_data[WIDTH*i +: WIDTH] != exp_data[WIDTH*i +: WIDTH]);
            end
        end
        // Descending loop leaves the lowest mismatching channel selected.
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (mism_v[i]) begin
                first_ch  = CW'(i);
                first_res = res_data[WIDTH*i +: WIDTH];
                first_exp = exp_data[WIDTH*i +: WIDTH];
            end
        end
    end

    assign halted_n = halted | new_halt;
    assign all_halt = &halted_n;
    assign tmo_hit  = (cycles == 32'(TIMEOUT - 1));
    assign cmp_last = cmp_v && (cmp_a == ADDR_W'(DEPTH - 1));
    assign ok_n     = ok & ~mism_v;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // A halt completing in the timeout cycle still counts: all_halt is checked first.
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_n = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (all_halt)     state_n = S_SCAN;
                else if (tmo_hit) state_n = S_DONE;
            end
            S_SCAN: begin
                busy = 1'b1;
                if (cmp_last) state_n = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_n = S_RUN;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NCHAN; i++) hold[i] <= '0;
            res_addr   <= '0;
            timeout    <= 1'b0;
            halted     <= '0;
            pass       <= '0;
            ok         <= '0;
            fail_valid <= 1'b0;
            fail_chan  <= '0;
            fail_addr  <= '0;
            fail_found <= '0;
            fail_exp   <= '0;
            cycles     <= '0;
            issue_done <= 1'b0;
            cmp_v      <= 1'b0;
            cmp_a      <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        for (int i = 0; i < NCHAN; i++) hold[i] <= '0;
                        timeout    <= 1'b0;
                        halted     <= '0;
                        pass       <= '0;
                        ok         <= '1;
                        fail_valid <= 1'b0;
                        fail_chan  <= '0;
                        fail_addr  <= '0;
                        fail_found <= '0;
                        fail_exp   <= '0;
                        cycles     <= '0;
                        issue_done <= 1'b0;
                        cmp_v      <= 1'b0;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < NCHAN; i++) begin
                        if (!is_halt_op[i]) begin
                            hold[i] <= '0;
                        end else if (hold[i] != HW'(HALT_HOLD)) begin
                            hold[i] <= hold[i] + HW'(1);
                        end
                    end
                    halted <= halted_n;
                    if (all_halt) begin
                        res_addr   <= '0;
                        issue_done <= 1'b0;
                        cmp_v      <= 1'b0;
                    end else if (tmo_hit) begin
                        timeout <= 1'b1;
                        pass    <= '0;
                    end else begin
                        cycles <= cycles + 32'd1;
                    end
                end
                S_SCAN: begin
                    // Memories return data one cycle after the address; cmp_v/cmp_a follow it.
                    cmp_v <= !issue_done;
                    cmp_a <= res_addr;
                    if (!issue_done) begin
                        if (res_addr == ADDR_W'(DEPTH - 1)) issue_done <= 1'b1;
                        else                                res_addr   <= res_addr + ADDR_W'(1);
                    end
                    ok <= ok_n;
                    if (!fail_valid && (|mism_v)) begin
                        fail_valid <= 1'b1;
                        fail_chan  <= first_ch;
                        fail_addr  <= cmp_a;
                        fail_found <= first_res;
                        fail_exp   <= first_exp;
                    end
                    if (cmp_last) pass <= halted & ok_n;
                end
                default: ;
            endcase
        end
    end

endmodule
